// File: rtl/match_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_pkg                                                                  |
// | Phase and winner encodings plus small scoring helpers for match_ctrl.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package match_pkg;

  localparam logic [2:0] c_PH_IDLE       = 3'd0;
  localparam logic [2:0] c_PH_COUNTDOWN  = 3'd1;
  localparam logic [2:0] c_PH_FIGHT      = 3'd2;
  localparam logic [2:0] c_PH_ROUND_END  = 3'd3;
  localparam logic [2:0] c_PH_MATCH_OVER = 3'd4;

  localparam logic [1:0] c_WIN_NONE = 2'b00;
  localparam logic [1:0] c_WIN_P1   = 2'b01;
  localparam logic [1:0] c_WIN_P2   = 2'b11;
  localparam logic [1:0] c_WIN_DRAW = 2'b10;

  // Larger value wins; a tie is a draw. Shared by health and wins comparison.
  function automatic logic [1:0] pick_winner(input logic [3:0] a, input logic [3:0] b);
    if (a > b)      return c_WIN_P1;
    else if (b > a) return c_WIN_P2;
    else            return c_WIN_DRAW;
  endfunction

  function automatic logic [1:0] inc_sat(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_ctrl_sec_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sec_tick_gen                                                               |
// | One-cycle tick every TICK_DIV clocks, restartable by a synchronous clear.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sec_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | match_ctrl                                                                 |
// | Best-of-N round/match sequencer wrapped around the fighting game core.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module match_ctrl #(
  parameter int TICK_DIV          = 100_000_000,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int ROUND_SECONDS     = 60,
  parameter int BANNER_SECONDS    = 3,
  parameter int WINS_NEEDED       = 2,
  parameter int MAX_ROUNDS        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic [6:0] p1_btns,
  input  logic [6:0] p2_btns,
  input  logic [1:0] finish,
  input  logic [3:0] p1_health,
  input  logic [3:0] p2_health,
  output logic [6:0] p1_inputs,
  output logic [6:0] p2_inputs,
  output logic       game_rst_n,
  output logic [2:0] phase,
  output logic [3:0] countdown,
  output logic [6:0] time_left,
  output logic [2:0] round_num,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner
);

  import match_pkg::*;

  localparam logic [3:0] c_CD_INIT     = 4'(COUNTDOWN_SECONDS);
  localparam logic [6:0] c_RND_INIT    = 7'(ROUND_SECONDS);
  localparam logic [6:0] c_BANNER_INIT = 7'(BANNER_SECONDS);
  localparam logic [1:0] c_WINS        = 2'(WINS_NEEDED);
  localparam logic [2:0] c_MAX_RND     = 3'(MAX_ROUNDS);

  logic [2:0] r_phase,        w_phase_nxt;
  logic [3:0] r_countdown,    w_countdown_nxt;
  logic [6:0] r_time_left,    w_time_left_nxt;
  logic [2:0] r_round_num,    w_round_num_nxt;
  logic [1:0] r_p1_wins,      w_p1_wins_nxt;
  logic [1:0] r_p2_wins,      w_p2_wins_nxt;
  logic [1:0] r_round_winner, w_round_winner_nxt;
  logic [1:0] r_match_winner, w_match_winner_nxt;
  logic [6:0] r_banner,       w_banner_nxt;
  logic       r_game_rst_n;
  logic       r_start_prev;

  logic       w_start_edge;
  logic       w_tick;
  logic       w_phase_clr;
  logic       w_match_done;
  logic [1:0] w_result;

  assign w_start_edge = start_btn & ~r_start_prev;
  assign w_phase_clr  = (w_phase_nxt != r_phase);

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (w_phase_clr),
    .tick  (w_tick)
  );

  // A KO reported by the game outranks the health comparison used on timeout.
  assign w_result     = finish[0] ? finish : pick_winner(p1_health, p2_health);
  assign w_match_done = (r_p1_wins >= c_WINS) || (r_p2_wins >= c_WINS) ||
                        (r_round_num >= c_MAX_RND);

  always_comb begin
    w_phase_nxt        = r_phase;
    w_countdown_nxt    = r_countdown;
    w_time_left_nxt    = r_time_left;
    w_round_num_nxt    = r_round_num;
    w_p1_wins_nxt      = r_p1_wins;
    w_p2_wins_nxt      = r_p2_wins;
    w_round_winner_nxt = r_round_winner;
    w_match_winner_nxt = r_match_winner;
    w_banner_nxt       = r_banner;

    case (r_phase)
      c_PH_IDLE, c_PH_MATCH_OVER: begin
        if (w_start_edge) begin
          w_phase_nxt        = c_PH_COUNTDOWN;
          w_countdown_nxt    = c_CD_INIT;
          w_round_num_nxt    = 3'd1;
          w_p1_wins_nxt      = 2'd0;
          w_p2_wins_nxt      = 2'd0;
          w_round_winner_nxt = c_WIN_NONE;
          w_match_winner_nxt = c_WIN_NONE;
        end
      end

      c_PH_COUNTDOWN: begin
        if (w_tick) begin
          if (r_countdown <= 4'd1) begin
            w_phase_nxt     = c_PH_FIGHT;
            w_countdown_nxt = 4'd0;
            w_time_left_nxt = c_RND_INIT;
          end else begin
            w_countdown_nxt = r_countdown - 4'd1;
          end
        end
      end

      c_PH_FIGHT: begin
        if (finish[0] || (w_tick && (r_time_left <= 7'd1))) begin
          w_phase_nxt        = c_PH_ROUND_END;
          w_round_winner_nxt = w_result;
          w_banner_nxt       = c_BANNER_INIT;
          if (!finish[0]) begin
            w_time_left_nxt = 7'd0;
          end
          if (w_result == c_WIN_P1) begin
            w_p1_wins_nxt = inc_sat(r_p1_wins);
          end
          if (w_result == c_WIN_P2) begin
            w_p2_wins_nxt = inc_sat(r_p2_wins);
          end
        end else if (w_tick) begin
          w_time_left_nxt = r_time_left - 7'd1;
        end
      end

      c_PH_ROUND_END: begin
        if (w_tick) begin
          if (r_banner > 7'd1) begin
            w_banner_nxt = r_banner - 7'd1;
          end else if (w_match_done) begin
            w_phase_nxt        = c_PH_MATCH_OVER;
            w_match_winner_nxt = pick_winner({2'b00, r_p1_wins}, {2'b00, r_p2_wins});
          end else begin
            w_phase_nxt        = c_PH_COUNTDOWN;
            w_countdown_nxt    = c_CD_INIT;
            w_round_num_nxt    = r_round_num + 3'd1;
            w_round_winner_nxt = c_WIN_NONE;
          end
        end
      end

      default: begin
        w_phase_nxt = c_PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_phase        <= c_PH_IDLE;
      r_countdown    <= 4'd0;
      r_time_left    <= 7'd0;
      r_round_num    <= 3'd0;
      r_p1_wins      <= 2'd0;
      r_p2_wins      <= 2'd0;
      r_round_winner <= c_WIN_NONE;
      r_match_winner <= c_WIN_NONE;
      r_banner       <= 7'd0;
      r_game_rst_n   <= 1'b0;
      // Treat the button as already pressed so holding it through reset cannot start a match.
      r_start_prev   <= 1'b1;
    end else begin
      r_phase        <= w_phase_nxt;
      r_countdown    <= w_countdown_nxt;
      r_time_left    <= w_time_left_nxt;
      r_round_num    <= w_round_num_nxt;
      r_p1_wins      <= w_p1_wins_nxt;
      r_p2_wins      <= w_p2_wins_nxt;
      r_round_winner <= w_round_winner_nxt;
      r_match_winner <= w_match_winner_nxt;
      r_banner       <= w_banner_nxt;
      r_game_rst_n   <= (w_phase_nxt == c_PH_FIGHT) || (w_phase_nxt == c_PH_ROUND_END) ||
                        (w_phase_nxt == c_PH_MATCH_OVER);
      r_start_prev   <= start_btn;
    end
  end

  assign p1_inputs    = (r_phase == c_PH_FIGHT) ? p1_btns : 7'd0;
  assign p2_inputs    = (r_phase == c_PH_FIGHT) ? p2_btns : 7'd0;
  assign game_rst_n   = r_game_rst_n;
  assign phase        = r_phase;
  assign countdown    = r_countdown;
  assign time_left    = r_time_left;
  assign round_num    = r_round_num;
  assign p1_wins      = r_p1_wins;
  assign p2_wins      = r_p2_wins;
  assign round_winner = r_round_winner;
  assign match_winner = r_match_winner;

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_match_ctrl                                                              |
// | Self-checking bench: round-outcome table, directed sequences, random run.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_match_ctrl;

  localparam int TD = 10;
  localparam int CD = 3;
  localparam int RS = 5;
  localparam int BS = 2;
  localparam int WN = 2;
  localparam int MR = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic [6:0] p1_btns, p2_btns;
  logic [1:0] finish;
  logic [3:0] p1_health, p2_health;
  logic [6:0] p1_inputs, p2_inputs;
  logic       game_rst_n;
  logic [2:0] phase;
  logic [3:0] countdown;
  logic [6:0] time_left;
  logic [2:0] round_num;
  logic [1:0] p1_wins, p2_wins, round_winner, match_winner;

  match_ctrl #(
    .TICK_DIV          (TD),
    .COUNTDOWN_SECONDS (CD),
    .ROUND_SECONDS     (RS),
    .BANNER_SECONDS    (BS),
    .WINS_NEEDED       (WN),
    .MAX_ROUNDS        (MR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .p1_btns      (p1_btns),
    .p2_btns      (p2_btns),
    .finish       (finish),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .p1_inputs    (p1_inputs),
    .p2_inputs    (p2_inputs),
    .game_rst_n   (game_rst_n),
    .phase        (phase),
    .countdown    (countdown),
    .time_left    (time_left),
    .round_num    (round_num),
    .p1_wins      (p1_wins),
    .p2_wins      (p2_wins),
    .round_winner (round_winner),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;

  // Reference model: phase plus cycles elapsed since that phase was entered.
  int m_phase = 0, m_cyc = 0, m_tl = 0, m_round = 0;
  int m_w1 = 0, m_w2 = 0, m_rw = 0, m_mw = 0;
  bit m_prev = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_enter(input int p);
    m_phase = p;
    m_cyc   = 0;
  endtask

  task automatic m_score(input int w);
    m_rw = w;
    if (w == 1) m_w1 = (m_w1 < 3) ? m_w1 + 1 : 3;
    if (w == 3) m_w2 = (m_w2 < 3) ? m_w2 + 1 : 3;
  endtask

  function automatic int cmp_win(input int a, input int b);
    return (a > b) ? 1 : ((b > a) ? 3 : 2);
  endfunction

  task automatic model_step();
    bit e;
    e      = start_btn && !m_prev;
    m_prev = start_btn;
    if (!reset) begin
      m_phase = 0; m_cyc = 0; m_tl = 0; m_round = 0;
      m_w1 = 0; m_w2 = 0; m_rw = 0; m_mw = 0; m_prev = 1'b1;
      return;
    end
    m_cyc++;
    case (m_phase)
      0, 4: if (e) begin
        m_enter(1); m_round = 1; m_w1 = 0; m_w2 = 0; m_rw = 0; m_mw = 0;
      end
      1: if (m_cyc == CD * TD) begin
        m_enter(2); m_tl = RS;
      end
      2: begin
        if (finish[0]) begin
          m_tl = RS - (m_cyc - 1) / TD;
          m_score(int'(finish));
          m_enter(3);
        end else begin
          m_tl = RS - m_cyc / TD;
          if (m_tl == 0) begin
            m_score(cmp_win(int'(p1_health), int'(p2_health)));
            m_enter(3);
          end
        end
      end
      3: if (m_cyc == BS * TD) begin
        if (m_w1 == WN || m_w2 == WN || m_round == MR) begin
          m_mw = cmp_win(m_w1, m_w2);
          m_enter(4);
        end else begin
          m_round++; m_rw = 0; m_enter(1);
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_model();
    logic [63:0] act, exp;
    int cd;
    cd  = (m_phase == 1) ? CD - m_cyc / TD : 0;
    act = {phase, countdown, time_left, round_num, p1_wins, p2_wins,
           round_winner, match_winner, game_rst_n, p1_inputs, p2_inputs};
    exp = {3'(m_phase), 4'(cd), 7'(m_tl), 3'(m_round), 2'(m_w1), 2'(m_w2),
           2'(m_rw), 2'(m_mw), (m_phase >= 2),
           (m_phase == 2) ? p1_btns : 7'd0, (m_phase == 2) ? p2_btns : 7'd0};
    chk("model", act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start_btn = 1'b0;
    finish = 2'b00;
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic wait_phase(input int p, input int budget, input string nm);
    int k;
    k = 0;
    while (phase !== 3'(p) && k < budget) begin
      step();
      k++;
    end
    chk(nm, 64'(phase), 64'(p));
  endtask

  typedef struct {
    int         kind;   // 0 early KO, 1 timeout, 2 KO on the final tick
    logic [1:0] fin;
    logic [3:0] h1, h2;
    logic [1:0] rw, w1, w2;
  } rec_t;

  rec_t tbl[8];
  int   rst_hold;

  initial begin
    tbl[0] = '{0, 2'b01, 4'd8,  4'd8,  2'b01, 2'd1, 2'd0};
    tbl[1] = '{0, 2'b11, 4'd8,  4'd8,  2'b11, 2'd0, 2'd1};
    tbl[2] = '{1, 2'b00, 4'd7,  4'd9,  2'b11, 2'd0, 2'd1};
    tbl[3] = '{1, 2'b00, 4'd8,  4'd8,  2'b10, 2'd0, 2'd0};
    tbl[4] = '{1, 2'b00, 4'd15, 4'd3,  2'b01, 2'd1, 2'd0};
    tbl[5] = '{1, 2'b00, 4'd0,  4'd0,  2'b10, 2'd0, 2'd0};
    tbl[6] = '{2, 2'b11, 4'd15, 4'd3,  2'b11, 2'd0, 2'd1};
    tbl[7] = '{2, 2'b01, 4'd0,  4'd15, 2'b01, 2'd1, 2'd0};

    reset = 1'b0; start_btn = 1'b0; finish = 2'b00;
    p1_btns = 7'h00; p2_btns = 7'h00; p1_health = 4'd8; p2_health = 4'd8;

    do_reset();
    chk("reset_phase", 64'(phase), 64'd0);
    chk("reset_outs", {countdown, time_left, round_num, p1_wins, p2_wins,
                       round_winner, match_winner, game_rst_n}, 64'd0);

    // Start-up timing and one KO round.
    pulse_start();
    chk("cd_phase", 64'(phase), 64'd1);
    chk("cd_value", 64'(countdown), 64'd3);
    chk("cd_round", 64'(round_num), 64'd1);
    chk("cd_rst_n", 64'(game_rst_n), 64'd0);
    repeat (29) step();
    chk("cd_last_sec", {phase, countdown}, {3'd1, 4'd1});
    step();
    chk("fight_entry", {phase, countdown, time_left, game_rst_n}, {3'd2, 4'd0, 7'd5, 1'b1});
    p1_btns = 7'h55; p2_btns = 7'h2A;
    #1;
    chk("pass_p1", 64'(p1_inputs), 64'h55);
    chk("pass_p2", 64'(p2_inputs), 64'h2A);
    finish = 2'b01;
    step();
    finish = 2'b00;
    chk("ko_p1", {phase, round_winner, p1_wins, p1_inputs}, {3'd3, 2'b01, 2'd1, 7'd0});
    repeat (19) step();
    chk("banner_hold", 64'(phase), 64'd3);
    step();
    chk("next_round", {phase, round_num, round_winner}, {3'd1, 3'd2, 2'b00});

    // P2 takes two rounds and the match.
    wait_phase(2, 60, "r2_fight");
    finish = 2'b11; step(); finish = 2'b00;
    chk("r2_p2wins", 64'(p2_wins), 64'd1);
    wait_phase(1, 40, "r3_cd");
    wait_phase(2, 60, "r3_fight");
    finish = 2'b11; step(); finish = 2'b00;
    chk("r3_p2wins", 64'(p2_wins), 64'd2);
    wait_phase(4, 40, "mo_p2");
    chk("mo_p2_result", {match_winner, round_num, p1_wins}, {2'b11, 3'd3, 2'd1});
    pulse_start();
    chk("restart", {phase, p1_wins, p2_wins, round_num, match_winner, round_winner},
        {3'd1, 2'd0, 2'd0, 3'd1, 2'b00, 2'b00});

    // Five drawn rounds exhaust the round cap.
    p1_health = 4'd8; p2_health = 4'd8;
    for (int i = 0; i < 5; i++) begin
      wait_phase(2, 80, "draw_fight");
      wait_phase(3, 80, "draw_end");
      chk("draw_rw", 64'(round_winner), 64'b10);
    end
    wait_phase(4, 40, "mo_draw");
    chk("mo_draw_result", {match_winner, round_num, p1_wins, p2_wins},
        {2'b10, 3'd5, 2'd0, 2'd0});

    // Reset mid-fight with start held high.
    pulse_start();
    wait_phase(2, 60, "rst_fight");
    repeat (5) step();
    start_btn = 1'b1;
    reset = 1'b0;
    step();
    chk("rst_all_zero", {phase, countdown, time_left, round_num, p1_wins, p2_wins,
                         round_winner, match_winner, game_rst_n, p1_inputs, p2_inputs}, 64'd0);
    reset = 1'b1;
    repeat (20) step();
    chk("rst_no_restart", 64'(phase), 64'd0);
    start_btn = 1'b0;

    // Round-outcome table, one fresh match per record.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      p1_health = tbl[r].h1;
      p2_health = tbl[r].h2;
      pulse_start();
      wait_phase(2, 60, "tbl_fight");
      if (tbl[r].kind == 0) begin
        repeat (3) step();
        finish = tbl[r].fin; step(); finish = 2'b00;
      end else if (tbl[r].kind == 1) begin
        wait_phase(3, 60, "tbl_timeout");
        chk("tbl_time_left", 64'(time_left), 64'd0);
      end else begin
        repeat (49) step();
        finish = tbl[r].fin; step(); finish = 2'b00;
      end
      chk($sformatf("tbl%0d_result", r), {phase, round_winner, p1_wins, p2_wins},
          {3'd3, tbl[r].rw, tbl[r].w1, tbl[r].w2});
    end

    // Randomised run against the model.
    do_reset();
    rst_hold = 0;
    for (int c = 0; c < 15000 && n_err < 20; c++) begin
      p1_btns = 7'($urandom);
      p2_btns = 7'($urandom);
      if ($urandom_range(149) == 0) start_btn = ~start_btn;
      finish = ($urandom_range(59) == 0) ? (($urandom_range(1) == 1) ? 2'b11 : 2'b01) : 2'b00;
      if ($urandom_range(29) == 0) p1_health = 4'($urandom);
      if ($urandom_range(29) == 0) p2_health = 4'($urandom);
      if (rst_hold > 0) begin
        reset = 1'b0;
        rst_hold--;
      end else if ($urandom_range(2999) == 0) begin
        reset = 1'b0;
        rst_hold = $urandom_range(2);
      end else begin
        reset = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
